host_mem_rdwr_arb: RTL

Two-source arbiter that shares one host-memory Avalon read/write channel between the DMA engine (source 0) and the kernel USM path (source 1). It sits between the two translated physical-address source paths and the physical-address side of the VTP service shim. Read and write channels are arbitrated independently with quantum-limited round-robin. Write bursts are never split. Read responses return in order and are steered back to the issuing source through a tag FIFO.

---
 rtl/host_mem_rdwr_arb_if.sv | 43 ++++
 rtl/host_mem_rdwr_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_rdwr_arb_if.sv
// Avalon read/write channel bundle shared by the arbiter's source and sink
// sides. N is the number of ports packed source-major into each bus: the
// source side uses N=2, the host-memory sink side uses N=1. Read data is
// broadcast, so rd_readdata is a single DATA_W bus regardless of N.
interface host_mem_rdwr_arb_if #(
   parameter int N       = 1,
   parameter int ADDR_W  = 48,
   parameter int DATA_W  = 512,
   parameter int BURST_W = 7,
   parameter int USER_W  = 4
);
   logic [N-1:0]              rd_read;
   logic [N-1:0]              rd_waitrequest;
   logic [N*ADDR_W-1:0]       rd_address;
   logic [N*BURST_W-1:0]      rd_burstcount;
   logic [N*USER_W-1:0]       rd_user;
   logic [DATA_W-1:0]         rd_readdata;
   logic [N-1:0]              rd_readdatavalid;

   logic [N-1:0]              wr_write;
   logic [N-1:0]              wr_waitrequest;
   logic [N*ADDR_W-1:0]       wr_address;
   logic [N*BURST_W-1:0]      wr_burstcount;
   logic [N*USER_W-1:0]       wr_user;
   logic [N*DATA_W-1:0]       wr_writedata;
   logic [N*(DATA_W/8)-1:0]   wr_byteenable;

   // Issues commands and write data, consumes waitrequest and read responses.
   modport master (
      output rd_read, rd_address, rd_burstcount, rd_user,
      input  rd_waitrequest, rd_readdata, rd_readdatavalid,
      output wr_write, wr_address, wr_burstcount, wr_user, wr_writedata, wr_byteenable,
      input  wr_waitrequest
   );

   // Accepts commands and write data, produces waitrequest and read responses.
   modport slave (
      input  rd_read, rd_address, rd_burstcount, rd_user,
      output rd_waitrequest, rd_readdata, rd_readdatavalid,
      input  wr_write, wr_address, wr_burstcount, wr_user, wr_writedata, wr_byteenable,
      output wr_waitrequest
   );
endinterface

// File: rtl/host_mem_rdwr_arb.sv
// Two-source arbiter sharing one host-memory Avalon read/write channel between
// the DMA engine (source 0) and the kernel USM path (source 1). Read and write
// channels use independent quantum-limited round-robin; write bursts are never
// split; read responses return in order and are steered back to the issuing
// source by a tag FIFO recording {source, burstcount} per accepted command.
module host_mem_rdwr_arb #(
   parameter int ADDR_W        = 48,
   parameter int DATA_W        = 512,
   parameter int BURST_W       = 7,
   parameter int USER_W        = 4,
   parameter int QUANTUM       = 4,
   parameter int RD_FIFO_DEPTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   host_mem_rdwr_arb_if.slave  src,
   host_mem_rdwr_arb_if.master snk
);

   localparam int QW   = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam int AW   = $clog2(RD_FIFO_DEPTH);
   localparam int BE_W = DATA_W / 8;
   localparam logic [QW-1:0]      Q_LAST     = QW'(QUANTUM - 1);
   localparam logic [AW:0]        FIFO_FULLC = (AW+1)'(RD_FIFO_DEPTH);
   localparam logic [BURST_W-1:0] ONE_BEAT   = BURST_W'(1);

   typedef struct packed {
      logic               src;
      logic [BURST_W-1:0] burstcount;
   } rd_tag_t;

   // ------------------------------------------------------------------
   // Read command path
   // ------------------------------------------------------------------
   logic          rd_gnt;
   logic [QW-1:0] rd_q;
   logic          rd_req_gnt;
   logic          rd_req_oth;
   logic          rd_accept;
   logic          rd_switch;
   logic [1:0]    rd_wait_vec;

   // Tag FIFO state
   rd_tag_t       tag_mem [RD_FIFO_DEPTH];
   logic [AW-1:0] tag_wptr;
   logic [AW-1:0] tag_rptr;
   logic [AW:0]   tag_count;
   logic          fifo_full;
   logic          tag_empty;
   rd_tag_t       tag_head;

   // Response steering state
   logic [BURST_W-1:0] rsp_beats;
   logic [BURST_W-1:0] rsp_remaining;
   logic               rsp_beat;
   logic               rsp_last;
   logic [1:0]         rsp_valid_vec;

   assign rd_req_gnt = src.rd_read[rd_gnt];
   assign rd_req_oth = src.rd_read[~rd_gnt];
   assign fifo_full  = (tag_count == FIFO_FULLC);
   assign tag_empty  = (tag_count == '0);

   assign snk.rd_read       = ~reset & rd_req_gnt & ~fifo_full;
   assign snk.rd_address    = src.rd_address[int'(rd_gnt)*ADDR_W +: ADDR_W];
   assign snk.rd_burstcount = src.rd_burstcount[int'(rd_gnt)*BURST_W +: BURST_W];
   assign snk.rd_user       = src.rd_user[int'(rd_gnt)*USER_W +: USER_W];

   assign rd_accept = snk.rd_read & ~snk.rd_waitrequest;
   assign rd_switch = rd_req_oth & (~rd_req_gnt | (rd_accept & (rd_q == Q_LAST)));

   // Only the granted source may see waitrequest low; everyone waits in reset.
   always_comb begin
      rd_wait_vec = 2'b11;
      if (!reset) begin
         rd_wait_vec[rd_gnt] = snk.rd_waitrequest | fifo_full;
      end
   end
   assign src.rd_waitrequest = rd_wait_vec;

   // Read grant and quantum: reset on a switch, saturate with no competitor.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_gnt <= 1'b0;
         rd_q   <= '0;
      end else if (rd_switch) begin
         rd_gnt <= ~rd_gnt;
         rd_q   <= '0;
      end else if (rd_accept && (rd_q != Q_LAST)) begin
         rd_q   <= rd_q + QW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Read tag FIFO
   // ------------------------------------------------------------------
   assign tag_head = tag_mem[tag_rptr];

   // Tag storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (rd_accept) begin
         tag_mem[tag_wptr] <= '{src: rd_gnt, burstcount: snk.rd_burstcount};
      end
   end

   // Pointers and occupancy; a push and a pop in the same cycle are allowed.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_wptr  <= '0;
         tag_rptr  <= '0;
         tag_count <= '0;
      end else begin
         if (rd_accept) begin
            tag_wptr <= tag_wptr + AW'(1);
         end
         if (rsp_last) begin
            tag_rptr <= tag_rptr + AW'(1);
         end
         case ({rd_accept, rsp_last})
            2'b10:   tag_count <= tag_count + (AW+1)'(1);
            2'b01:   tag_count <= tag_count - (AW+1)'(1);
            default: tag_count <= tag_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read response steering
   // ------------------------------------------------------------------
   assign rsp_remaining = (rsp_beats == '0) ? tag_head.burstcount : rsp_beats;
   assign rsp_beat      = ~reset & snk.rd_readdatavalid & ~tag_empty;
   assign rsp_last      = rsp_beat & (rsp_remaining <= ONE_BEAT);

   // Deliver each response beat only to the source at the FIFO head.
   always_comb begin
      rsp_valid_vec = 2'b00;
      if (rsp_beat) begin
         rsp_valid_vec[tag_head.src] = 1'b1;
      end
   end
   assign src.rd_readdatavalid = rsp_valid_vec;
   assign src.rd_readdata      = snk.rd_readdata;

   // Count down the beats of the head command; zero means "load from head".
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_beats <= '0;
      end else if (rsp_beat) begin
         rsp_beats <= rsp_last ? '0 : (rsp_remaining - ONE_BEAT);
      end
   end

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   logic               wr_gnt;
   logic [QW-1:0]      wr_q;
   logic [BURST_W-1:0] wr_beats;
   logic               wr_in_burst;
   logic               wr_req_gnt;
   logic               wr_req_oth;
   logic               wr_accept;
   logic               wr_last;
   logic               wr_burst_done;
   logic               wr_switch;
   logic [1:0]         wr_wait_vec;

   assign wr_req_gnt = src.wr_write[wr_gnt];
   assign wr_req_oth = src.wr_write[~wr_gnt];

   assign snk.wr_write      = ~reset & wr_req_gnt;
   assign snk.wr_address    = src.wr_address[int'(wr_gnt)*ADDR_W +: ADDR_W];
   assign snk.wr_burstcount = src.wr_burstcount[int'(wr_gnt)*BURST_W +: BURST_W];
   assign snk.wr_user       = src.wr_user[int'(wr_gnt)*USER_W +: USER_W];
   assign snk.wr_writedata  = src.wr_writedata[int'(wr_gnt)*DATA_W +: DATA_W];
   assign snk.wr_byteenable = src.wr_byteenable[int'(wr_gnt)*BE_W +: BE_W];

   assign wr_accept     = snk.wr_write & ~snk.wr_waitrequest;
   assign wr_last       = wr_in_burst ? (wr_beats == ONE_BEAT)
                                      : (snk.wr_burstcount <= ONE_BEAT);
   assign wr_burst_done = wr_accept & wr_last;
   assign wr_switch     = wr_req_oth &
                          ((~wr_in_burst & ~wr_req_gnt) |
                           (wr_burst_done & (wr_q == Q_LAST)));

   // Only the granted writer may see waitrequest low; everyone waits in reset.
   always_comb begin
      wr_wait_vec = 2'b11;
      if (!reset) begin
         wr_wait_vec[wr_gnt] = snk.wr_waitrequest;
      end
   end
   assign src.wr_waitrequest = wr_wait_vec;

   // Burst tracking from the first beat's burstcount, plus grant and quantum
   // bookkeeping that only moves between whole bursts.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_gnt      <= 1'b0;
         wr_q        <= '0;
         wr_beats    <= '0;
         wr_in_burst <= 1'b0;
      end else begin
         if (wr_accept) begin
            if (!wr_in_burst) begin
               if (snk.wr_burstcount > ONE_BEAT) begin
                  wr_in_burst <= 1'b1;
                  wr_beats    <= snk.wr_burstcount - ONE_BEAT;
               end
            end else begin
               wr_beats <= wr_beats - ONE_BEAT;
               if (wr_beats == ONE_BEAT) begin
                  wr_in_burst <= 1'b0;
               end
            end
         end
         if (wr_switch) begin
            wr_gnt <= ~wr_gnt;
            wr_q   <= '0;
         end else if (wr_burst_done && (wr_q != Q_LAST)) begin
            wr_q   <= wr_q + QW'(1);
         end
      end
   end

`ifndef SYNTHESIS
   logic rsp_orphan_seen;

   // A response beat with no outstanding command is dropped; remember it and
   // keep complaining so the protocol error cannot go unnoticed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_orphan_seen <= 1'b0;
      end else begin
         if (snk.rd_readdatavalid && tag_empty) begin
            rsp_orphan_seen <= 1'b1;
         end
         assert (!rsp_orphan_seen);
      end
   end
`endif

endmodule
